rom_fetch_arbiter: RTL and testbench

//  Shares the single ROM/SDRAM read port between the M68K program ROM windows and the Z80 sound ROM
//  (fixed + banked). Consumes the chip-select decodes, translates addresses to ROM byte offsets,

---
 rtl/rom_fetch_arbiter.sv | 102 ++++++++++
 tb/tb_rom_fetch_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch_arbiter.sv
// rom_fetch_arbiter: round-robin sharing of the ROM read port between M68K program ROM and Z80 sound ROM
module rom_fetch_arbiter #(
  parameter int                ROM_AW     = 24,
  parameter logic [ROM_AW-1:0] M68K_BASE  = 24'h000000,
  parameter logic [ROM_AW-1:0] M68K2_BASE = 24'h040000,
  parameter logic [ROM_AW-1:0] Z80_BASE   = 24'h080000,
  parameter int                TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [23:0]       m68k_a,
  input  logic              m68k_rom_cs,
  input  logic              m68k_rom_2_cs,
  output logic [15:0]       m68k_rom_data,
  output logic              m68k_rom_valid,
  input  logic [15:0]       z80_addr,
  input  logic [7:0]        z80_din,
  input  logic              z80_rom_cs,
  input  logic              z80_banked_cs,
  input  logic              z80_bank_set_cs,
  output logic [7:0]        z80_rom_data,
  output logic              z80_wait_n,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              rom_req,
  input  logic              rom_ack,
  input  logic [15:0]       rom_data
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t            state_q;
  logic              owner_z80_q, last_z80_q, abort_q, m68k_done_q, z80_done_q, bank_set_q;
  logic [4:0]        bank_q;
  logic [7:0]        tcnt_q;
  logic              m68k_cs, z80_cs, m68k_pend, z80_pend, gnt_z80, owner_cs, fin, keep;
  logic              m68k_del, z80_del;
  logic [15:0]       fin_data;
  logic [ROM_AW-1:0] m68k_off, z80_off;
  logic              unused_ok;
  assign unused_ok = ^{m68k_a[23:18], m68k_a[0], z80_addr[15], z80_din[7:5]};
  assign m68k_cs   = m68k_rom_cs | m68k_rom_2_cs;
  assign z80_cs    = z80_rom_cs | z80_banked_cs;
  assign m68k_pend = m68k_cs & ~m68k_done_q;
  assign z80_pend  = z80_cs & ~z80_done_q;
  assign z80_wait_n = ~z80_pend;
  // On a tie the source that did not win last time is granted
  assign gnt_z80   = z80_pend & (~m68k_pend | ~last_z80_q);
  assign m68k_off  = (m68k_rom_cs ? M68K_BASE : M68K2_BASE) + ROM_AW'({m68k_a[17:1], 1'b0});
  assign z80_off   = z80_rom_cs ? Z80_BASE + ROM_AW'({z80_addr[14:1], 1'b0})
                                : Z80_BASE + ROM_AW'(32'h8000) + ROM_AW'({bank_q, z80_addr[13:1], 1'b0});
  assign owner_cs  = owner_z80_q ? z80_cs : m68k_cs;
  assign fin       = (state_q == S_WAIT) & (rom_ack | (tcnt_q == 8'(TIMEOUT)));
  assign fin_data  = rom_ack ? rom_data : 16'hFFFF;
  // A fetch whose owner dropped cs at any point is completed on the port but never delivered
  assign keep      = fin & owner_cs & ~abort_q;
  assign m68k_del  = keep & ~owner_z80_q;
  assign z80_del   = keep & owner_z80_q;
  // Arbitration FSM, bank register, done flags and registered return data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      owner_z80_q    <= 1'b0;
      last_z80_q     <= 1'b1;
      abort_q        <= 1'b0;
      m68k_done_q    <= 1'b0;
      z80_done_q     <= 1'b0;
      bank_set_q     <= 1'b0;
      bank_q         <= '0;
      tcnt_q         <= '0;
      rom_addr       <= '0;
      rom_req        <= 1'b0;
      m68k_rom_data  <= '0;
      m68k_rom_valid <= 1'b0;
      z80_rom_data   <= '0;
    end else begin
      bank_set_q     <= z80_bank_set_cs;
      if (z80_bank_set_cs && !bank_set_q) bank_q <= z80_din[4:0];
      m68k_done_q    <= m68k_cs & (m68k_done_q | m68k_del);
      z80_done_q     <= z80_cs & (z80_done_q | z80_del);
      m68k_rom_valid <= m68k_cs & (m68k_rom_valid | m68k_del);
      if (m68k_del) m68k_rom_data <= fin_data;
      if (z80_del) z80_rom_data <= z80_addr[0] ? fin_data[7:0] : fin_data[15:8];
      case (state_q)
        S_IDLE: if (m68k_pend || z80_pend) begin
          owner_z80_q <= gnt_z80;
          rom_addr    <= gnt_z80 ? z80_off : m68k_off;
          rom_req     <= 1'b1;
          tcnt_q      <= '0;
          abort_q     <= 1'b0;
          state_q     <= S_WAIT;
        end
        S_WAIT: if (fin) begin
          rom_req    <= 1'b0;
          last_z80_q <= owner_z80_q;
          state_q    <= S_IDLE;
        end else begin
          tcnt_q <= tcnt_q + 8'd1;
          if (!owner_cs) abort_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// tb_rom_fetch_arbiter: directed table-driven checks of rom_fetch_arbiter
module tb_rom_fetch_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [23:0] m68k_a = '0;
  logic        m68k_rom_cs = 1'b0, m68k_rom_2_cs = 1'b0;
  logic [15:0] m68k_rom_data;
  logic        m68k_rom_valid;
  logic [15:0] z80_addr = '0;
  logic [7:0]  z80_din = '0;
  logic        z80_rom_cs = 1'b0, z80_banked_cs = 1'b0, z80_bank_set_cs = 1'b0;
  logic [7:0]  z80_rom_data;
  logic        z80_wait_n;
  logic [23:0] rom_addr;
  logic        rom_req;
  logic        rom_ack = 1'b0;
  logic [15:0] rom_data = '0;
  int          n_chk = 0, n_fail = 0;

  typedef struct {
    logic        z;
    logic [1:0]  sel;
    logic [23:0] addr;
    logic [7:0]  bank;
    logic [15:0] d;
    logic [23:0] ea;
    logic [15:0] ed;
  } vec_t;
  vec_t vecs[9];

  rom_fetch_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m68k_a(m68k_a), .m68k_rom_cs(m68k_rom_cs), .m68k_rom_2_cs(m68k_rom_2_cs),
    .m68k_rom_data(m68k_rom_data), .m68k_rom_valid(m68k_rom_valid),
    .z80_addr(z80_addr), .z80_din(z80_din), .z80_rom_cs(z80_rom_cs),
    .z80_banked_cs(z80_banked_cs), .z80_bank_set_cs(z80_bank_set_cs),
    .z80_rom_data(z80_rom_data), .z80_wait_n(z80_wait_n),
    .rom_addr(rom_addr), .rom_req(rom_req), .rom_ack(rom_ack), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic ack(input logic [15:0] d);
    rom_ack = 1'b1;
    rom_data = d;
    @(negedge clk);
    rom_ack = 1'b0;
  endtask

  task automatic wait_req(input string nm);
    int k = 0;
    while (!rom_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk(nm, rom_req, 1);
  endtask

  task automatic set_bank(input logic [7:0] b);
    @(negedge clk);
    z80_din = b;
    z80_bank_set_cs = 1'b1;
    @(negedge clk);
    z80_bank_set_cs = 1'b0;
  endtask

  task automatic drop_all();
    m68k_rom_cs = 1'b0;
    m68k_rom_2_cs = 1'b0;
    z80_rom_cs = 1'b0;
    z80_banked_cs = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic fetch(input int i, input vec_t v);
    string p = $sformatf("v%0d_", i);
    if (v.z && v.sel[1]) set_bank(v.bank);
    @(negedge clk);
    if (v.z) begin
      z80_addr = v.addr[15:0];
      z80_rom_cs = v.sel[0];
      z80_banked_cs = v.sel[1];
    end else begin
      m68k_a = v.addr;
      m68k_rom_cs = v.sel[0];
      m68k_rom_2_cs = v.sel[1];
    end
    #1;
    if (v.z) chk({p, "wait_n_low"}, z80_wait_n, 0);
    wait_req({p, "req"});
    chk({p, "rom_addr"}, rom_addr, v.ea);
    chk({p, "valid_early"}, m68k_rom_valid, 0);
    @(negedge clk);
    @(negedge clk);
    ack(v.d);
    chk({p, "req_drop"}, rom_req, 0);
    if (v.z) begin
      chk({p, "z80_data"}, z80_rom_data, v.ed);
      chk({p, "wait_n_high"}, z80_wait_n, 1);
    end else begin
      chk({p, "m68k_data"}, m68k_rom_data, v.ed);
      chk({p, "valid"}, m68k_rom_valid, 1);
      @(negedge clk);
      chk({p, "valid_hold"}, m68k_rom_valid, 1);
    end
    drop_all();
    if (!v.z) chk({p, "valid_clr"}, m68k_rom_valid, 0);
  endtask

  task automatic both(input logic z_first, input logic [15:0] d1, input logic [15:0] d2);
    @(negedge clk);
    m68k_a = 24'h000100;
    m68k_rom_cs = 1'b1;
    z80_addr = 16'h0201;
    z80_rom_cs = 1'b1;
    wait_req("arb_req1");
    chk("arb_addr1", rom_addr, z_first ? 24'h080200 : 24'h000100);
    ack(d1);
    if (!z_first) chk("arb_wait_n_mid", z80_wait_n, 0);
    wait_req("arb_req2");
    chk("arb_addr2", rom_addr, z_first ? 24'h000100 : 24'h080200);
    ack(d2);
    chk("arb_m68k", m68k_rom_data, z_first ? d2 : d1);
    chk("arb_z80", z80_rom_data, z_first ? {8'h00, d1[7:0]} : {8'h00, d2[7:0]});
    chk("arb_valid", m68k_rom_valid, 1);
    chk("arb_wait_n", z80_wait_n, 1);
    drop_all();
  endtask

  initial begin
    int k;
    vecs[0] = '{1'b0, 2'b01, 24'h000012, 8'h00, 16'hA55A, 24'h000012, 16'hA55A};
    vecs[1] = '{1'b0, 2'b10, 24'h800004, 8'h00, 16'h1234, 24'h040004, 16'h1234};
    vecs[2] = '{1'b0, 2'b01, 24'h03FFFF, 8'h00, 16'hBEEF, 24'h03FFFE, 16'hBEEF};
    vecs[3] = '{1'b0, 2'b10, 24'h83FFFE, 8'h00, 16'h0F0F, 24'h07FFFE, 16'h0F0F};
    vecs[4] = '{1'b1, 2'b01, 24'h001235, 8'h00, 16'hC3D4, 24'h081234, 16'h00D4};
    vecs[5] = '{1'b1, 2'b01, 24'h007FFE, 8'h00, 16'h9876, 24'h087FFE, 16'h0098};
    vecs[6] = '{1'b1, 2'b10, 24'h008000, 8'h00, 16'h4321, 24'h088000, 16'h0043};
    vecs[7] = '{1'b1, 2'b10, 24'h00C001, 8'hE3, 16'h5A6B, 24'h094000, 16'h006B};
    vecs[8] = '{1'b1, 2'b10, 24'h00FFFF, 8'h1F, 16'h1357, 24'h107FFE, 16'h0057};
    repeat (3) @(negedge clk);
    chk("rst_req", rom_req, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_valid", m68k_rom_valid, 0);
    chk("rst_m68k_data", m68k_rom_data, 0);
    chk("rst_z80_data", z80_rom_data, 0);
    chk("rst_wait_n", z80_wait_n, 1);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 9; i++) fetch(i, vecs[i]);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    both(1'b0, 16'h1111, 16'h2222);
    fetch(9, vecs[0]);
    both(1'b1, 16'h3344, 16'h5566);
    @(negedge clk);
    m68k_a = 24'h000020;
    m68k_rom_cs = 1'b1;
    wait_req("to_req");
    k = 0;
    while (!m68k_rom_valid && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("to_cycles", k, 256);
    chk("to_data", m68k_rom_data, 16'hFFFF);
    chk("to_req_drop", rom_req, 0);
    drop_all();
    fetch(10, vecs[1]);
    @(negedge clk);
    m68k_a = 24'h000040;
    m68k_rom_cs = 1'b1;
    wait_req("ab_req");
    m68k_rom_cs = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ack(16'h5555);
    chk("ab_valid", m68k_rom_valid, 0);
    chk("ab_req_drop", rom_req, 0);
    chk("ab_data_kept", m68k_rom_data, 16'h1234);
    fetch(11, vecs[2]);
    @(negedge clk);
    z80_addr = 16'h0010;
    z80_rom_cs = 1'b1;
    wait_req("mr_req");
    reset_n = 1'b0;
    z80_rom_cs = 1'b0;
    #1;
    chk("mr_req", rom_req, 0);
    chk("mr_addr", rom_addr, 0);
    chk("mr_valid", m68k_rom_valid, 0);
    chk("mr_m68k_data", m68k_rom_data, 0);
    chk("mr_z80_data", z80_rom_data, 0);
    chk("mr_wait_n", z80_wait_n, 1);
    @(negedge clk);
    reset_n = 1'b1;
    ack(16'hDEAD);
    @(negedge clk);
    chk("mr_stray_req", rom_req, 0);
    chk("mr_stray_z80", z80_rom_data, 0);
    chk("mr_stray_valid", m68k_rom_valid, 0);
    fetch(12, '{1'b1, 2'b01, 24'h000011, 8'h00, 16'h7788, 24'h080010, 16'h0088});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
